// File: rtl/my_countdown_timer.sv
// my_countdown_timer: BCD MM:SS countdown with preset load, start/pause, DONE level, BO pulse on 00:01->00:00 (in: CP CR LD D_MIN D_SEC START PAUSE; out: Q_MIN Q_SEC RUNNING DONE BO)
module my_countdown_timer #(
  parameter int TICK_DIV     = 100_000_000,
  parameter int MIN_TENS_MAX = 5
) (
  input  logic       CP,
  input  logic       CR,
  input  logic       LD,
  input  logic [7:0] D_MIN,
  input  logic [7:0] D_SEC,
  input  logic       START,
  input  logic       PAUSE,
  output logic [7:0] Q_MIN,
  output logic [7:0] Q_SEC,
  output logic       RUNNING,
  output logic       DONE,
  output logic       BO
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [3:0] MT = 4'(MIN_TENS_MAX);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_DONE} state_t;
  state_t state;
  logic [PW-1:0] psc;
  logic tick, zero, last, b0, b1, b2;
  logic [7:0] dec_min, dec_sec, ld_min, ld_sec;
  always_comb begin
    tick = psc == PW'(TICK_DIV - 1);
    zero = {Q_MIN, Q_SEC} == 16'h0000;
    last = {Q_MIN, Q_SEC} == 16'h0001;
    b0 = Q_SEC[3:0] == 4'd0;
    b1 = b0 && Q_SEC[7:4] == 4'd0;
    b2 = b1 && Q_MIN[3:0] == 4'd0;
    dec_sec = {b0 ? (Q_SEC[7:4] == 4'd0 ? 4'd5 : Q_SEC[7:4] - 4'd1) : Q_SEC[7:4],
               b0 ? 4'd9 : Q_SEC[3:0] - 4'd1};
    dec_min = {b2 ? Q_MIN[7:4] - 4'd1 : Q_MIN[7:4],
               b1 ? (Q_MIN[3:0] == 4'd0 ? 4'd9 : Q_MIN[3:0] - 4'd1) : Q_MIN[3:0]};
    ld_sec = {D_SEC[7:4] > 4'd5 ? 4'd5 : D_SEC[7:4], D_SEC[3:0] > 4'd9 ? 4'd9 : D_SEC[3:0]};
    ld_min = {D_MIN[7:4] > MT ? MT : D_MIN[7:4], D_MIN[3:0] > 4'd9 ? 4'd9 : D_MIN[3:0]};
  end
  always_ff @(posedge CP) begin
    if (CR) begin
      state   <= S_IDLE;
      Q_MIN   <= 8'h00;
      Q_SEC   <= 8'h00;
      psc     <= '0;
      RUNNING <= 1'b0;
      DONE    <= 1'b0;
      BO      <= 1'b0;
    end else begin
      BO <= 1'b0;
      if (LD) begin
        state   <= S_IDLE;
        Q_MIN   <= ld_min;
        Q_SEC   <= ld_sec;
        psc     <= '0;
        RUNNING <= 1'b0;
        DONE    <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (START && !PAUSE && !zero) begin
            state   <= S_RUN;
            psc     <= '0;
            RUNNING <= 1'b1;
          end
          S_RUN: if (PAUSE) begin
            state   <= S_PAUSED;
            RUNNING <= 1'b0;
          end else begin
            psc <= tick ? '0 : psc + PW'(1);
            if (tick && !zero) begin
              Q_MIN <= dec_min;
              Q_SEC <= dec_sec;
            end
            if (tick && last) begin
              state   <= S_DONE;
              RUNNING <= 1'b0;
              DONE    <= 1'b1;
              BO      <= 1'b1;
            end
          end
          // prescaler keeps its held value so the resumed period is completed, not restarted
          S_PAUSED: if (START && !PAUSE) begin
            state   <= S_RUN;
            RUNNING <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_my_countdown_timer.sv
// tb_my_countdown_timer: table-driven and hand-sequenced scoreboard bench for my_countdown_timer with TICK_DIV=4
module tb_my_countdown_timer;
  logic clk = 1'b0;
  logic cr, ld, start, pause;
  logic [7:0] d_min, d_sec, q_min, q_sec;
  logic running, done, bo;
  int total = 0;
  int passed = 0;
  int stepno = 0;
  typedef struct {
    logic cr, ld, start, pause;
    logic [7:0] dmin, dsec, qm, qs;
    logic run, dn, b;
  } vec_t;
  vec_t vecs[$];
  logic [18:0] exp_q[$];
  my_countdown_timer #(.TICK_DIV(4), .MIN_TENS_MAX(5)) dut (
    .CP(clk), .CR(cr), .LD(ld), .D_MIN(d_min), .D_SEC(d_sec), .START(start), .PAUSE(pause),
    .Q_MIN(q_min), .Q_SEC(q_sec), .RUNNING(running), .DONE(done), .BO(bo)
  );
  always #5 clk = ~clk;
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end
  function automatic vec_t mk(input logic c, l, s, p, input logic [7:0] dm, ds, qm, qs,
                              input logic r, d, b);
    vec_t t;
    t.cr = c; t.ld = l; t.start = s; t.pause = p; t.dmin = dm; t.dsec = ds;
    t.qm = qm; t.qs = qs; t.run = r; t.dn = d; t.b = b;
    return t;
  endfunction
  task automatic v(input int n, input logic c, l, s, p, input logic [7:0] dm, ds, qm, qs,
                   input logic r, d, b);
    for (int i = 0; i < n; i++) vecs.push_back(mk(c, l, s, p, dm, ds, qm, qs, r, d, b));
  endtask
  task automatic step(input vec_t t);
    logic [18:0] got, e;
    @(negedge clk);
    cr = t.cr; ld = t.ld; start = t.start; pause = t.pause; d_min = t.dmin; d_sec = t.dsec;
    exp_q.push_back({t.qm, t.qs, t.run, t.dn, t.b});
    @(posedge clk);
    #1;
    got = {q_min, q_sec, running, done, bo};
    e = exp_q.pop_front();
    total++;
    stepno++;
    if (got !== e)
      $display("FAIL step%0d {Q_MIN,Q_SEC,RUN,DONE,BO}: got %h:%h %b%b%b required %h:%h %b%b%b",
               stepno, got[18:11], got[10:3], got[2], got[1], got[0], e[18:11], e[10:3], e[2], e[1], e[0]);
    else passed++;
  endtask
  task automatic hs(input int n, input logic c, l, s, p, input logic [7:0] dm, ds, qm, qs,
                    input logic r, d, b);
    for (int i = 0; i < n; i++) step(mk(c, l, s, p, dm, ds, qm, qs, r, d, b));
  endtask
  initial begin
    cr = 1'b1; ld = 1'b0; start = 1'b0; pause = 1'b0; d_min = 8'h00; d_sec = 8'h00;
    //  n  cr ld st pa dmin   dsec    Q_MIN  Q_SEC  run dn bo
    v(1, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    v(1, 0, 1, 0, 0, 8'h00, 8'h03, 8'h00, 8'h03, 0, 0, 0);
    v(1, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h03, 1, 0, 0);
    v(3, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h03, 1, 0, 0);
    v(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h02, 1, 0, 0);
    v(3, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h02, 1, 0, 0);
    v(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h01, 1, 0, 0);
    v(3, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h01, 1, 0, 0);
    v(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 1);
    v(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 0);
    v(1, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 0);
    v(1, 0, 0, 1, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 0);
    v(1, 0, 1, 0, 0, 8'h10, 8'h00, 8'h10, 8'h00, 0, 0, 0);
    v(1, 0, 0, 1, 0, 8'h00, 8'h00, 8'h10, 8'h00, 1, 0, 0);
    v(3, 0, 0, 0, 0, 8'h00, 8'h00, 8'h10, 8'h00, 1, 0, 0);
    v(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h09, 8'h59, 1, 0, 0);
    v(1, 0, 1, 0, 0, 8'h01, 8'h00, 8'h01, 8'h00, 0, 0, 0);
    v(1, 0, 0, 1, 0, 8'h00, 8'h00, 8'h01, 8'h00, 1, 0, 0);
    v(3, 0, 0, 0, 0, 8'h00, 8'h00, 8'h01, 8'h00, 1, 0, 0);
    v(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h59, 1, 0, 0);
    v(1, 0, 1, 0, 0, 8'hAB, 8'h7F, 8'h59, 8'h59, 0, 0, 0);
    v(1, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    v(1, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    v(1, 0, 1, 0, 0, 8'h00, 8'h10, 8'h00, 8'h10, 0, 0, 0);
    v(1, 0, 0, 1, 1, 8'h00, 8'h00, 8'h00, 8'h10, 0, 0, 0);
    foreach (vecs[i]) step(vecs[i]);
    // pause after two prescaler counts, hold, resume: decrement two cycles after resume
    hs(1, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h10, 1, 0, 0);
    hs(2, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h10, 1, 0, 0);
    hs(1, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h10, 0, 0, 0);
    hs(10, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h10, 0, 0, 0);
    hs(1, 0, 0, 1, 1, 8'h00, 8'h00, 8'h00, 8'h10, 0, 0, 0);
    hs(1, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h10, 1, 0, 0);
    hs(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h10, 1, 0, 0);
    hs(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h09, 1, 0, 0);
    // load during RUN returns to IDLE with the new preset
    hs(1, 0, 1, 0, 0, 8'h00, 8'h05, 8'h00, 8'h05, 0, 0, 0);
    hs(3, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h05, 0, 0, 0);
    // reach DONE, then clear
    hs(1, 0, 1, 0, 0, 8'h00, 8'h01, 8'h00, 8'h01, 0, 0, 0);
    hs(1, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h01, 1, 0, 0);
    hs(3, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h01, 1, 0, 0);
    hs(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 1);
    hs(1, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    // clear mid-count: no BO, back to IDLE, START on 00:00 ignored
    hs(1, 0, 1, 0, 0, 8'h00, 8'h02, 8'h00, 8'h02, 0, 0, 0);
    hs(1, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h02, 1, 0, 0);
    hs(2, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h02, 1, 0, 0);
    hs(1, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    hs(4, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
